// File: rtl/ofm_write_cu_c1.sv
// Producer-side control for the 2-bank ping-pong OFM buffer: write addressing, bank occupancy, consumer handshake.
// Optional sticky overflow flag enabled by defining OFM_OVERFLOW_FLAG_EN.
module ofm_write_cu_c1 #(
   parameter int OFM_SIZE         = 28,
   parameter int ADDRESS_SIZE_OFM = $clog2(OFM_SIZE**2)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_valid_in,
   output logic                        o_stall_to_previous,
   output logic                        o_ofm_enable_write_next,
   output logic [ADDRESS_SIZE_OFM-1:0] o_ofm_address_write_next,
   output logic                        o_ofm_sel_write,
   output logic                        o_start_to_next,
   input  logic                        i_end_from_next,
   output logic                        o_ifm_sel_next,
   output logic                        o_overflow_flag
);

   localparam logic [ADDRESS_SIZE_OFM-1:0] LAST_ADDR = ADDRESS_SIZE_OFM'(OFM_SIZE*OFM_SIZE - 1);

   typedef enum logic [1:0] {S_WAIT, S_ACK, S_BUSY} state_t;

   state_t                      r_state;
   logic [1:0]                  r_cnt;
   logic [ADDRESS_SIZE_OFM-1:0] r_addr;
   logic                        r_sel_write;
   logic                        r_sel_next;
   logic                        r_start;

   logic       w_stall;
   logic       w_wen;
   logic       w_frame_done;
   logic       w_release;
   logic [1:0] w_cnt_nxt;

   assign w_stall      = (r_cnt == 2'd2);
   assign w_wen        = i_valid_in & ~w_stall;
   assign w_frame_done = w_wen & (r_addr == LAST_ADDR);
   assign w_release    = (r_state == S_BUSY) & i_end_from_next;

   // A fill and a release in the same cycle cancel out.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_frame_done && !w_release)
         w_cnt_nxt = r_cnt + 2'd1;
      else if (!w_frame_done && w_release)
         w_cnt_nxt = r_cnt - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_WAIT;
         r_cnt       <= 2'd0;
         r_addr      <= '0;
         r_sel_write <= 1'b0;
         r_sel_next  <= 1'b0;
         r_start     <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_start <= 1'b0;
         if (w_wen) begin
            if (w_frame_done) begin
               r_addr      <= '0;
               r_sel_write <= ~r_sel_write;
            end else begin
               r_addr <= r_addr + 1'b1;
            end
         end
         // Offer uses the next count so a just-filled bank is offered one cycle after its last write.
         case (r_state)
            S_WAIT: begin
               if (i_end_from_next && (w_cnt_nxt != 2'd0)) begin
                  r_start <= 1'b1;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               if (!i_end_from_next)
                  r_state <= S_BUSY;
            end
            S_BUSY: begin
               if (i_end_from_next) begin
                  r_sel_next <= ~r_sel_next;
                  r_state    <= S_WAIT;
               end
            end
            default: r_state <= S_WAIT;
         endcase
      end
   end

`ifdef OFM_OVERFLOW_FLAG_EN
   logic r_overflow;

   always_ff @(posedge clk) begin
      if (reset)
         r_overflow <= 1'b0;
      else if (i_valid_in && w_stall)
         r_overflow <= 1'b1;
   end

   assign o_overflow_flag = r_overflow;
`else
   assign o_overflow_flag = 1'b0;
`endif

   assign o_stall_to_previous      = w_stall;
   assign o_ofm_enable_write_next  = w_wen;
   assign o_ofm_address_write_next = r_addr;
   assign o_ofm_sel_write          = r_sel_write;
   assign o_start_to_next          = r_start;
   assign o_ifm_sel_next           = r_sel_next;

endmodule

// File: tb/tb_ofm_write_cu_c1.sv
// Bench for ofm_write_cu_c1 with OFM_SIZE=4: frame-count model checked every cycle plus directed literal checks.
module tb_ofm_write_cu_c1;

   localparam int N     = 4;
   localparam int FRAME = N * N;
   localparam int A     = $clog2(N * N);
`ifdef OFM_OVERFLOW_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         valid_in = 1'b0;
   logic         end_from_next = 1'b0;
   logic         stall, wen, sel_write, start, sel_next, ovf;
   logic [A-1:0] addr;

   int n_chk = 0;
   int n_err = 0;

   ofm_write_cu_c1 #(.OFM_SIZE(N)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .i_valid_in               (valid_in),
      .o_stall_to_previous      (stall),
      .o_ofm_enable_write_next  (wen),
      .o_ofm_address_write_next (addr),
      .o_ofm_sel_write          (sel_write),
      .o_start_to_next          (start),
      .i_end_from_next          (end_from_next),
      .o_ifm_sel_next           (sel_next),
      .o_overflow_flag          (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: words written, frames filled, frames consumed; consumer phase 0=idle 1=offered 2=reading.
   bit m_valid = 1'b0;
   int m_words, m_fw, m_fr, m_phase;
   bit m_start, m_ovf;

   always @(posedge clk) begin
      int  cnt;
      bit  wr, fd, rel, offer;
      if (reset) begin
         m_valid = 1'b1;
         m_words = 0; m_fw = 0; m_fr = 0; m_phase = 0;
         m_start = 1'b0; m_ovf = 1'b0;
      end else if (m_valid) begin
         cnt   = m_fw - m_fr;
         wr    = valid_in && (cnt < 2);
         if (OVF_EN && valid_in && cnt == 2) m_ovf = 1'b1;
         fd    = wr && ((m_words % FRAME) == FRAME - 1);
         rel   = (m_phase == 2) && end_from_next;
         offer = (m_phase == 0) && end_from_next && (cnt + int'(fd) >= 1);
         if (offer) m_phase = 1;
         else if (m_phase == 1 && !end_from_next) m_phase = 2;
         else if (rel) m_phase = 0;
         if (wr) m_words++;
         if (fd) m_fw++;
         if (rel) m_fr++;
         m_start = offer;
      end
   end

   always @(negedge clk) begin
      int cnt;
      if (m_valid && !reset) begin
         cnt = m_fw - m_fr;
         chk("m_stall", int'(stall), int'(cnt == 2));
         chk("m_wen", int'(wen), int'(valid_in && cnt < 2));
         chk("m_addr", int'(addr), m_words % FRAME);
         chk("m_sel_write", int'(sel_write), m_fw % 2);
         chk("m_sel_next", int'(sel_next), m_fr % 2);
         chk("m_start", int'(start), int'(m_start));
         chk("m_ovf", int'(ovf), int'(m_ovf));
      end
   end

   task automatic step(input bit v, input bit e);
      valid_in = v;
      end_from_next = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0);
      step(0, 0);
      reset = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();
      chk("rst_addr", int'(addr), 0);
      chk("rst_sel_write", int'(sel_write), 0);
      chk("rst_sel_next", int'(sel_next), 0);
      chk("rst_start", int'(start), 0);
      chk("rst_stall", int'(stall), 0);
      chk("rst_ovf", int'(ovf), 0);

      // T1: one full frame with an idle consumer
      for (int i = 0; i < FRAME - 1; i++) step(1, 1);
      chk("t1_addr15", int'(addr), 15);
      chk("t1_start_early", int'(start), 0);
      step(1, 1);
      chk("t1_start", int'(start), 1);
      chk("t1_addr_wrap", int'(addr), 0);
      chk("t1_sel_write", int'(sel_write), 1);
      chk("t1_sel_next", int'(sel_next), 0);
      step(0, 1);
      chk("t1_start_pulse", int'(start), 0);

      // T2: busy consumer, two frames fill both banks
      do_reset();
      for (int i = 0; i < 2 * FRAME; i++) step(1, 0);
      chk("t2_stall", int'(stall), 1);
      chk("t2_addr", int'(addr), 0);
      chk("t2_sel_write", int'(sel_write), 0);
      chk("t2_wen_blocked", int'(wen), 0);
      step(1, 0);
      chk("t2_addr_held", int'(addr), 0);
      chk("t6_ovf", int'(ovf), OVF_EN ? 1 : 0);

      // T3: consumer drains one bank
      step(0, 1);
      chk("t3_start", int'(start), 1);
      step(0, 0); step(0, 0); step(0, 0);
      chk("t3_stall_still", int'(stall), 1);
      step(0, 1);
      chk("t3_stall_clr", int'(stall), 0);
      chk("t3_sel_next", int'(sel_next), 1);
      step(1, 0);
      chk("t3_resume_addr", int'(addr), 1);
      chk("t3_resume_bank", int'(sel_write), 0);
      chk("t6_ovf_sticky", int'(ovf), OVF_EN ? 1 : 0);

      // T4: frame completion coincides with bank release
      do_reset();
      for (int i = 0; i < FRAME; i++) step(1, 1);
      step(0, 0);
      for (int i = 0; i < FRAME - 1; i++) step(1, 0);
      chk("t4_stall_pre", int'(stall), 0);
      step(1, 1);
      chk("t4_sel_write", int'(sel_write), 0);
      chk("t4_sel_next", int'(sel_next), 1);
      chk("t4_stall", int'(stall), 0);

      // T5: reset mid-frame with one bank occupied
      for (int i = 0; i < 9; i++) step(1, 0);
      chk("t5_addr9", int'(addr), 9);
      reset = 1'b1;
      step(1, 1);
      reset = 1'b0;
      chk("t5_addr", int'(addr), 0);
      chk("t5_sel_write", int'(sel_write), 0);
      chk("t5_sel_next", int'(sel_next), 0);
      chk("t5_start", int'(start), 0);
      chk("t5_stall", int'(stall), 0);
      step(0, 1);
      chk("t5_no_start", int'(start), 0);
      step(0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
